// File: rtl/adc_frame_packer.sv
// Captures DEPTH sample sets of NUM_CH channels into RAM, then replays them as byte-wide AXI-Stream packets.
// Latency: first tvalid 2 cycles after the final capture write; sustains 1 byte/cycle with no bubbles.
// Backpressure: m_axis_tready stalls readout with tdata/tlast held; ADC input is never stalled. Header: ADC_FRAME_PACKER_HEADER_EN.
module adc_frame_packer #(
    parameter int NUM_CH      = 6,
    parameter int SAMPLE_W    = 16,
    parameter int DEPTH       = 512,
    parameter int PKT_SAMPLES = 64
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic                       abort,
    input  logic [1:0]                 mode,
    input  logic [SAMPLE_W-1:0]        trig_level,
    input  logic                       din_valid,
    input  logic [NUM_CH*SAMPLE_W-1:0] din,
    output logic [7:0]                 m_axis_tdata,
    output logic                       m_axis_tvalid,
    input  logic                       m_axis_tready,
    output logic                       m_axis_tlast,
    output logic                       busy,
    output logic                       frame_done,
    output logic                       overflow
);
    localparam int DW   = NUM_CH * SAMPLE_W;
    localparam int BPC  = SAMPLE_W / 8;
    localparam int BPS  = NUM_CH * BPC;
    localparam int NPKT = DEPTH / PKT_SAMPLES;
    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int BW   = (BPS > 1) ? $clog2(BPS) : 1;
    localparam int SW   = (PKT_SAMPLES > 1) ? $clog2(PKT_SAMPLES) : 1;
    localparam int PW   = (NPKT > 1) ? $clog2(NPKT) : 1;

    typedef enum logic [1:0] {IDLE = 2'd0, ARM = 2'd1, CAPTURE = 2'd2, READOUT = 2'd3} state_t;
    state_t state, state_nxt;

    logic          cont_q, prev_vld, trig, we, rd_active, take, ram_en, fin_hs, stop;
    logic          end_set, end_pkt, end_frame, set_vld, src_done, abort_pend, hdr_phase;
    logic [SAMPLE_W-1:0] prev_ch0;
    logic [AW-1:0] wr_addr, rd_set;
    logic [BW-1:0] byte_idx;
    logic [SW-1:0] set_idx;
    logic [PW-1:0] pkt_idx;
    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] ram_q;
    logic [7:0]    set_bytes [BPS];
    logic [7:0]    src_byte;

    assign trig = (state == ARM) && din_valid && prev_vld
                  && ($signed(prev_ch0) < $signed(trig_level))
                  && ($signed(trig_level) <= $signed(din[SAMPLE_W-1:0]));
    assign we        = din_valid && !abort && ((state == CAPTURE) || trig);
    assign rd_active = (state == READOUT);
    assign stop      = abort_pend || abort;
    assign end_set   = !hdr_phase && (byte_idx == BW'(BPS - 1));
    assign end_pkt   = end_set && (set_idx == SW'(PKT_SAMPLES - 1));
    assign end_frame = end_pkt && (pkt_idx == PW'(NPKT - 1));
    assign take      = rd_active && set_vld && !src_done && (!m_axis_tvalid || m_axis_tready);
    // The next set is fetched on the same edge the last byte of the current one leaves, so ram_q never runs dry.
    assign ram_en    = rd_active && (!set_vld || (take && end_set));
    assign fin_hs    = rd_active && src_done && m_axis_tvalid && m_axis_tready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = (mode == 2'b10) ? ARM : CAPTURE;
            ARM:     if (abort) state_nxt = IDLE;
                     else if (trig) state_nxt = CAPTURE;
            CAPTURE: if (abort) state_nxt = IDLE;
                     else if (din_valid && wr_addr == AW'(DEPTH - 1)) state_nxt = READOUT;
            READOUT: if (fin_hs) state_nxt = (cont_q && !stop) ? CAPTURE : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cont_q     <= 1'b0;
            overflow   <= 1'b0;
            prev_ch0   <= '0;
            prev_vld   <= 1'b0;
            wr_addr    <= '0;
            frame_done <= 1'b0;
        end else begin
            if (state == IDLE && start) begin
                cont_q   <= (mode == 2'b01);
                overflow <= 1'b0;
            end else if (rd_active && din_valid && cont_q) begin
                overflow <= 1'b1;
            end
            if (state == ARM && din_valid) begin
                prev_ch0 <= din[SAMPLE_W-1:0];
                prev_vld <= 1'b1;
            end else if (state != ARM) begin
                prev_vld <= 1'b0;
            end
            if (we)                    wr_addr <= wr_addr + AW'(1);
            else if (state != CAPTURE) wr_addr <= '0;
            frame_done <= fin_hs && !stop;
        end
    end

    always_ff @(posedge clk) begin
        if (we)     mem[wr_addr] <= din;
        if (ram_en) ram_q <= mem[rd_set];
    end

    // Byte order within a set: ch0 first, each sample MSB byte first.
    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        for (genvar b = 0; b < BPC; b++) begin : g_byte
            assign set_bytes[c*BPC+b] = ram_q[c*SAMPLE_W + (BPC-1-b)*8 +: 8];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            set_vld    <= 1'b0;
            src_done   <= 1'b0;
            abort_pend <= 1'b0;
            byte_idx   <= '0;
            set_idx    <= '0;
            pkt_idx    <= '0;
            rd_set     <= '0;
        end else if (!rd_active) begin
            set_vld    <= 1'b0;
            src_done   <= 1'b0;
            abort_pend <= 1'b0;
            byte_idx   <= '0;
            set_idx    <= '0;
            pkt_idx    <= '0;
            rd_set     <= '0;
        end else begin
            abort_pend <= stop;
            if (ram_en) begin
                set_vld <= 1'b1;
                rd_set  <= rd_set + AW'(1);
            end
            if (take) begin
                if (end_frame || (end_pkt && stop)) src_done <= 1'b1;
                if (!hdr_phase) begin
                    if (end_set) begin
                        byte_idx <= '0;
                        if (end_pkt) begin
                            set_idx <= '0;
                            pkt_idx <= pkt_idx + PW'(1);
                        end else begin
                            set_idx <= set_idx + SW'(1);
                        end
                    end else begin
                        byte_idx <= byte_idx + BW'(1);
                    end
                end
            end
        end
    end

`ifdef ADC_FRAME_PACKER_HEADER_EN
    logic [1:0]  hdr_idx;
    logic [15:0] frame_cnt;
    logic [7:0]  hdr_byte;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hdr_phase <= 1'b1;
            hdr_idx   <= '0;
            frame_cnt <= '0;
        end else begin
            if (fin_hs && !stop) frame_cnt <= frame_cnt + 16'd1;
            if (!rd_active) begin
                hdr_phase <= 1'b1;
                hdr_idx   <= '0;
            end else if (take) begin
                if (hdr_phase) begin
                    hdr_idx <= hdr_idx + 2'd1;
                    if (hdr_idx == 2'd3) hdr_phase <= 1'b0;
                end else if (end_pkt) begin
                    hdr_phase <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        hdr_byte = 8'(NUM_CH);
        case (hdr_idx)
            2'd0:    hdr_byte = frame_cnt[15:8];
            2'd1:    hdr_byte = frame_cnt[7:0];
            2'd2:    hdr_byte = 8'(pkt_idx);
            default: hdr_byte = 8'(NUM_CH);
        endcase
    end

    assign src_byte = hdr_phase ? hdr_byte : set_bytes[byte_idx];
`else
    assign hdr_phase = 1'b0;
    assign src_byte  = set_bytes[byte_idx];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tlast  <= 1'b0;
        end else if (take) begin
            m_axis_tvalid <= 1'b1;
            m_axis_tdata  <= src_byte;
            m_axis_tlast  <= end_pkt;
        end else if (m_axis_tready) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
        end
    end
endmodule

// File: tb/tb_adc_frame_packer.sv
// Directed bench for adc_frame_packer: reference byte model, AXI stall checks, mode/abort/reset scenarios.
`timescale 1ns/1ps
module tb_adc_frame_packer;
    localparam int NUM_CH = 6, SAMPLE_W = 16, DEPTH = 512, PKT_SAMPLES = 64;
    localparam int DW = NUM_CH * SAMPLE_W;
    localparam int BPS = NUM_CH * SAMPLE_W / 8;
    localparam int PAY = PKT_SAMPLES * BPS;
`ifdef ADC_FRAME_PACKER_HEADER_EN
    localparam int HDR = 4;
`else
    localparam int HDR = 0;
`endif
    localparam int PKT_LEN = PAY + HDR;
    localparam int NPKT = DEPTH / PKT_SAMPLES;
    localparam int FRAME_LEN = NPKT * PKT_LEN;

    logic clk = 1'b0, rst_n, start, abort, din_valid, m_axis_tready;
    logic [1:0] mode;
    logic [SAMPLE_W-1:0] trig_level;
    logic [DW-1:0] din;
    logic [7:0] m_axis_tdata;
    logic m_axis_tvalid, m_axis_tlast, busy, frame_done, overflow;

    adc_frame_packer #(.NUM_CH(NUM_CH), .SAMPLE_W(SAMPLE_W), .DEPTH(DEPTH), .PKT_SAMPLES(PKT_SAMPLES)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .mode(mode), .trig_level(trig_level),
        .din_valid(din_valid), .din(din), .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast), .busy(busy),
        .frame_done(frame_done), .overflow(overflow)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ch k of set n carries n*16+k
    function automatic logic [DW-1:0] pat(input int n);
        logic [DW-1:0] r;
        r = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) r = {r[DW-SAMPLE_W-1:0], 16'(n * 16 + k)};
        return r;
    endfunction

    function automatic logic [DW-1:0] with_ch0(input int n, input logic [15:0] v);
        logic [DW-1:0] r;
        r = pat(n);
        r[15:0] = v;
        return r;
    endfunction

    function automatic logic [7:0] exp_byte(input int q);
        int n, r;
        logic [15:0] s;
        n = q / BPS;
        r = q % BPS;
        s = 16'(n * 16 + r / 2);
        return (r % 2 == 0) ? s[15:8] : s[7:0];
    endfunction

    task automatic do_start(input logic [1:0] m);
        mode = m;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic feed(input int from, input int to);
        for (int n = from; n < to; n++) begin
            din = pat(n);
            din_valid = 1'b1;
            step();
        end
        din_valid = 1'b0;
    endtask

    task automatic rx(input bit rnd, input bit chk_pay, input int fc0, input int abort_at, input int max_done,
                      output int pkts, output int bytes, output int mism, output int done,
                      output int to, output logic [31:0] first4);
        int fb, p, o;
        logic [15:0] fc;
        logic [7:0] e, hd;
        logic hl;
        bit ck, stall, ab_done;
        pkts = 0; bytes = 0; mism = 0; done = 0; to = 1; first4 = '0;
        stall = 0; ab_done = 0; hd = '0; hl = 1'b0;
        for (int cyc = 0; cyc < 40000; cyc++) begin
            if (stall && (m_axis_tvalid !== 1'b1 || m_axis_tdata !== hd || m_axis_tlast !== hl)) mism++;
            m_axis_tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            abort = (bytes == abort_at) && !ab_done;
            if (abort) ab_done = 1;
            stall = m_axis_tvalid && !m_axis_tready;
            hd = m_axis_tdata;
            hl = m_axis_tlast;
            if (m_axis_tvalid && m_axis_tready) begin
                fc = 16'(fc0 + bytes / FRAME_LEN);
                fb = bytes % FRAME_LEN;
                p = fb / PKT_LEN;
                o = fb % PKT_LEN;
                if (m_axis_tlast !== (o == PKT_LEN - 1)) mism++;
                if (o == PKT_LEN - 1) pkts++;
                if (o < HDR) begin
                    e = (o == 0) ? fc[15:8] : (o == 1) ? fc[7:0] : (o == 2) ? 8'(p) : 8'(NUM_CH);
                    ck = 1;
                end else begin
                    e = exp_byte(p * PAY + o - HDR);
                    ck = chk_pay;
                    if (fb - HDR < 4) first4 = {first4[23:0], m_axis_tdata};
                end
                if (ck && m_axis_tdata !== e) mism++;
                bytes++;
            end
            step();
            abort = 1'b0;
            if (frame_done) done++;
            if (!busy || done >= max_done) begin
                to = 0;
                break;
            end
        end
        for (int i = 0; i < 3; i++) begin
            if (m_axis_tvalid) mism++;
            m_axis_tready = 1'b1;
            step();
            if (frame_done) done++;
        end
    endtask

    int pk, by, mm, dn, tmo;
    logic [31:0] f4;
    logic seen_tv;
    logic [15:0] arm_tab [4];

    initial begin
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; mode = 2'b00; trig_level = '0;
        din_valid = 1'b0; din = '0; m_axis_tready = 1'b0;
        arm_tab = '{16'h00F0, 16'h8000, 16'h00F8, 16'h00FF};
        repeat (3) step();
        chk("rst_tvalid", m_axis_tvalid, 0);
        chk("rst_tlast", m_axis_tlast, 0);
        chk("rst_tdata", m_axis_tdata, 0);
        chk("rst_busy", busy, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_overflow", overflow, 0);
        rst_n = 1'b1;
        step();

        // single-shot, full-rate readout
        do_start(2'b00);
        chk("ss_busy_1cyc", busy, 1);
        feed(0, DEPTH);
        m_axis_tready = 1'b1;
        chk("ss_lat0", m_axis_tvalid, 0);
        step();
        chk("ss_lat1", m_axis_tvalid, 0);
        step();
        chk("ss_lat2", m_axis_tvalid, 1);
        rx(0, 1, 0, -1, 1, pk, by, mm, dn, tmo, f4);
        chk("ss_pkts", pk, NPKT);
        chk("ss_bytes", by, FRAME_LEN);
        chk("ss_data", mm, 0);
        chk("ss_first4", f4, 32'h0000_0001);
        chk("ss_done", dn, 1);
        chk("ss_timeout", tmo, 0);
        chk("ss_busy_end", busy, 0);

        // reserved mode behaves as single-shot; random backpressure
        do_start(2'b11);
        feed(0, DEPTH);
        rx(1, 1, 1, -1, 1, pk, by, mm, dn, tmo, f4);
        chk("rnd_pkts", pk, NPKT);
        chk("rnd_bytes", by, FRAME_LEN);
        chk("rnd_data_stall", mm, 0);
        chk("rnd_done", dn, 1);
        chk("rnd_timeout", tmo, 0);

        // threshold trigger on a rising ramp
        trig_level = 16'h0100;
        do_start(2'b10);
        chk("thr_busy", busy, 1);
        din_valid = 1'b1;
        din = with_ch0(0, 16'h00F0); step();
        din = with_ch0(0, 16'h00F8); step();
        din = with_ch0(0, 16'h0100); step();
        feed(1, DEPTH);
        rx(0, 0, 2, -1, 1, pk, by, mm, dn, tmo, f4);
        chk("thr_first4", f4, 32'h0100_0001);
        chk("thr_pkts", pk, NPKT);
        chk("thr_framing", mm, 0);
        chk("thr_done", dn, 1);
        chk("thr_timeout", tmo, 0);

        // ramp that never crosses (signed): stays armed
        do_start(2'b10);
        seen_tv = 1'b0;
        for (int i = 0; i < 40; i++) begin
            din = with_ch0(i, arm_tab[i % 4]);
            din_valid = 1'b1;
            step();
            seen_tv = seen_tv | m_axis_tvalid;
        end
        din_valid = 1'b0;
        chk("arm_busy", busy, 1);
        chk("arm_no_tvalid", seen_tv, 0);
        abort = 1'b1; step(); abort = 1'b0;
        chk("arm_abort_idle", busy, 0);

        // abort during capture at set 100
        do_start(2'b00);
        feed(0, 100);
        din = pat(100); din_valid = 1'b1; abort = 1'b1;
        step();
        abort = 1'b0; din_valid = 1'b0;
        chk("cap_abort_idle", busy, 0);
        seen_tv = 1'b0;
        for (int i = 0; i < 30; i++) begin
            step();
            seen_tv = seen_tv | m_axis_tvalid;
        end
        chk("cap_abort_no_tvalid", seen_tv, 0);

        // abort in the middle of packet 3
        do_start(2'b00);
        feed(0, DEPTH);
        rx(0, 1, 3, 3 * PKT_LEN + 50, 1, pk, by, mm, dn, tmo, f4);
        chk("rdab_pkts", pk, 4);
        chk("rdab_bytes", by, 4 * PKT_LEN);
        chk("rdab_data", mm, 0);
        chk("rdab_no_done", dn, 0);
        chk("rdab_timeout", tmo, 0);
        chk("rdab_idle", busy, 0);

        // asynchronous reset mid-packet
        do_start(2'b00);
        feed(0, DEPTH);
        m_axis_tready = 1'b1;
        repeat (100) step();
        chk("mid_tvalid", m_axis_tvalid, 1);
        rst_n = 1'b0;
        #1;
        chk("arst_tvalid", m_axis_tvalid, 0);
        chk("arst_busy", busy, 0);
        step();
        rst_n = 1'b1;
        step();

        // continuous mode after reset: frame counter restarts at 0
        chk("cont_ovf_pre", overflow, 0);
        din = pat(7);
        din_valid = 1'b1;
        do_start(2'b01);
        rx(0, 0, 0, -1, 3, pk, by, mm, dn, tmo, f4);
        chk("cont_done", dn, 3);
        chk("cont_pkts", pk, 3 * NPKT);
        chk("cont_bytes", by, 3 * FRAME_LEN);
        chk("cont_framing", mm, 0);
        chk("cont_timeout", tmo, 0);
        chk("cont_overflow", overflow, 1);
        chk("cont_busy", busy, 1);
        din_valid = 1'b0;
        abort = 1'b1; step(); abort = 1'b0;
        chk("cont_abort_idle", busy, 0);
        chk("ovf_sticky", overflow, 1);
        do_start(2'b00);
        chk("ovf_clear_on_start", overflow, 0);
        abort = 1'b1; step(); abort = 1'b0;
        chk("final_idle", busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
